// File: rtl/core_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN          - datapath width
//   NOP_INSTR     - instruction presented to decode when nothing is valid (addi x0,x0,0)
//   fetch_state_t - fetch controller states
//   fetch_entry_t - one buffered instruction word with its PC and redirect marker
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            branch;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head read.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push, wdata   - write request and data (accepted when not full, or full with pop)
//   pop           - remove head entry (ignored when empty)
//   clear         - empty the FIFO on this edge; wins over push/pop
//   rdata         - current head entry (undefined when empty)
//   full, empty   - occupancy flags
//   count         - number of stored entries
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  T                       wdata,
  output T                       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a word when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding decode.
// Keeps the fetch PC, issues word reads over a req/gnt/rvalid handshake, buffers
// returned words and presents the oldest to decode. A taken-branch redirect clears
// everything buffered and discards the responses of reads already in flight.
// Ports:
//   req                  - clock (rising edge, shared with decode)
//   reset                - asynchronous active-low reset (0 = in reset)
//   stall_in             - decode will not capture this cycle
//   redirect_in/_pc_in   - taken branch and its target (low two bits ignored)
//   imem_req_out/addr    - read request and address, held until granted
//   imem_gnt_in          - request accepted this cycle
//   imem_rvalid_in/rdata - in-order read response
//   instr_out/pc_out     - head instruction and its PC (NOP / 0 when empty)
//   valid_out            - head entry valid
//   branch_out           - head is the first instruction after a redirect
module fetch_stage import core_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            req,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            valid_out,
  output logic            branch_out
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            branch_flag;

  logic [CW-1:0]   out_next;
  logic [CW-1:0]   discard_after;
  logic            grant;
  logic            resp;
  logic            drop;
  logic            keep;

  fetch_entry_t    ent_wdata;
  fetch_entry_t    ent_head;
  logic            ent_push;
  logic            ent_pop;
  logic            ent_full;
  logic            ent_empty;
  logic [CW-1:0]   ent_count;

  logic [XLEN-1:0] pcq_head;
  logic            pcq_push;
  logic            pcq_pop;
  logic            pcq_full;
  logic            pcq_empty;
  logic [CW-1:0]   pcq_count;
  logic            unused_bits;

  // Credit rule: every granted read already owns a FIFO slot, so a request is only
  // raised while reads in flight plus buffered words leave room. That sum never rises
  // without a grant, so a pending request stays up until it is accepted.
  assign imem_req_out  = (state != BOOT) && !redirect_in &&
                         (({1'b0, outstanding} + {1'b0, ent_count}) < DEPTH_W);
  assign imem_addr_out = fetch_pc;

  assign grant = imem_req_out && imem_gnt_in;
  // Responses with nothing in flight belong to reads lost across a reset.
  assign resp  = imem_rvalid_in && (outstanding != '0);
  assign drop  = resp && (discard != '0);
  assign keep  = resp && (discard == '0) && !pcq_empty;

  assign out_next      = outstanding + CW'(grant) - CW'(resp);
  assign discard_after = drop ? discard - 1'b1 : discard;

  assign ent_push  = keep && !redirect_in && (!ent_full || ent_pop);
  assign ent_pop   = valid_out && !stall_in && !redirect_in;
  assign pcq_push  = grant && !pcq_full;
  assign pcq_pop   = keep && !redirect_in;
  assign ent_wdata = '{instr: imem_rdata_in, pc: pcq_head, branch: branch_flag};

  assign valid_out  = !ent_empty;
  assign instr_out  = ent_empty ? NOP_INSTR : ent_head.instr;
  assign pc_out     = ent_empty ? '0 : ent_head.pc;
  assign branch_out = !ent_empty && ent_head.branch;

  assign unused_bits = ^{redirect_pc_in[1:0], pcq_count};

  fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_entries (
    .clk   (req),
    .rst_n (reset),
    .push  (ent_push),
    .pop   (ent_pop),
    .clear (redirect_in),
    .wdata (ent_wdata),
    .rdata (ent_head),
    .full  (ent_full),
    .empty (ent_empty),
    .count (ent_count)
  );

  // PCs of granted reads still owed a kept response, in issue order.
  fetch_fifo #(.DEPTH(BUF_DEPTH), .T(logic [XLEN-1:0])) u_pc_queue (
    .clk   (req),
    .rst_n (reset),
    .push  (pcq_push),
    .pop   (pcq_pop),
    .clear (redirect_in),
    .wdata (fetch_pc),
    .rdata (pcq_head),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      branch_flag <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (redirect_in) begin
        fetch_pc    <= {redirect_pc_in[XLEN-1:2], 2'b00};
        // Everything still in flight after this edge is from the old path.
        discard     <= out_next;
        branch_flag <= 1'b1;
        case (state)
          BOOT:    state <= FETCH;
          FETCH:   state <= (out_next != '0) ? FLUSH : FETCH;
          default: state <= FLUSH;
        endcase
      end else begin
        if (grant)    fetch_pc    <= fetch_pc + XLEN'(4);
        if (drop)     discard     <= discard_after;
        if (ent_push) branch_flag <= 1'b0;
        case (state)
          BOOT:    state <= FETCH;
          FLUSH:   state <= (discard_after == '0) ? FETCH : FLUSH;
          default: state <= FETCH;
        endcase
      end
    end
  end
endmodule
